icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of the line count (64 lines, one 32-bit word per line).
REQ-002 clk_in  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 rdy_in  input  1  global ready; when low, all state and outputs are held.
REQ-005 fetch_able  input  1  fetch request from the fetcher; may stay high while the fetcher waits.
REQ-006 fetch_pc  input  32  byte address of the requested instruction.
REQ-007 stall  input  1  fetcher cannot consume this cycle.
REQ-008 flush  input  1  redirect; cancels any in-flight request.
REQ-009 ins_ready  output  1  instruction valid to the fetcher.
REQ-010 ins  output  32  instruction word.
REQ-011 mem_req  output  1  word read request to the memory controller.
REQ-012 mem_addr  output  32  word-aligned read address.
REQ-013 mem_resp_valid  input  1  memory response valid, single-cycle pulse.
REQ-014 mem_resp_data  input  32  memory response word.

Function
REQ-015 Address split: index = fetch_pc[INDEX_BITS+1:2], tag = fetch_pc[31:INDEX_BITS+2]; fetch_pc[1:0] ignored.
REQ-016 States: IDLE, MISS, RESP, GAP, DRAIN.
REQ-017 IDLE: a request is sampled on a rising edge where fetch_able=1; the cache latches the pc.
REQ-018 Hit on a sampled request (valid and tag equal): ins = line data, ins_ready=1 from that same edge, next state RESP (1-cycle latency).
REQ-019 Miss on a sampled request: mem_req=1, mem_addr={pc[31:2],2'b00} from that edge, next state MISS.
REQ-020 MISS: mem_req and mem_addr hold until the edge sampling mem_resp_valid=1.
REQ-021 At that edge: the line is written (valid=1, tag, data), mem_req=0, ins=mem_resp_data, ins_ready=1, next state RESP.
REQ-022 RESP: ins and ins_ready hold while stall=1; on an edge with stall=0 the word is consumed, ins_ready=0, next state GAP.
REQ-023 GAP: lasts exactly one cycle and ignores fetch_able (the request is stale), then IDLE.
REQ-024 Flush in IDLE, RESP or GAP: ins_ready=0, next state IDLE; the request is not sampled in that cycle.
REQ-025 Flush in MISS: ins_ready stays 0, next state DRAIN.
REQ-026 DRAIN: mem_req stays asserted until mem_resp_valid=1; the line is filled, ins_ready stays 0, then IDLE.
REQ-027 Flush during DRAIN has no additional effect.
REQ-028 mem_resp_valid outside MISS/DRAIN is ignored; no array write occurs.
REQ-029 At most one memory request is outstanding at any time.
REQ-030 When rdy_in=0: no sampling, no array write, all outputs held; a mem_resp_valid pulse during rdy_in=0 is the controller's responsibility to hold.

Reset
REQ-031 While rst_in=0, immediately and independent of clk_in: state=IDLE, all valid bits=0, ins_ready=0, ins=0, mem_req=0, mem_addr=0.
REQ-032 Reset mid-miss abandons the request with no fill; tag and data arrays need no reset.

Configuration
REQ-033 With macro ICACHE_STATS_EN defined, the block adds outputs hit_cnt (32) and miss_cnt (32):
  - hit_cnt increments on each sampled hit; miss_cnt increments on each sampled miss.
  - Both reset to 0 and wrap at 2^32.
  - Neither counts during flush or rdy_in=0.
REQ-034 Without ICACHE_STATS_EN, those ports and counters do not exist; behaviour is otherwise identical.

Verification
REQ-035 Cold miss: reset, fetch pc=0x100.
  - Required: mem_req=1 and mem_addr=0x100 next cycle.
  - Respond 0x00500093 after 3 cycles -> ins_ready=1, ins=0x00500093 at the response edge.
  - Then GAP for one cycle, then IDLE.
REQ-036 Hit after fill: fetch pc=0x100 again -> ins_ready=1, ins=0x00500093 one edge after sampling, mem_req stays 0.
REQ-037 Conflict: fill 0x100, then fetch 0x200 (same index at INDEX_BITS=6) -> miss, refill, line replaced; a later fetch of 0x100 misses again.
REQ-038 Stall hold: hit with stall=1 for 4 cycles -> ins_ready and ins stable for 4 cycles; consumed on the first stall=0 edge.
REQ-039 Flush mid-miss: miss on 0x300, flush the next cycle, respond 0xDEADBEEF.
  - Required: ins_ready never asserts.
  - A later fetch of 0x300 hits with 0xDEADBEEF.
REQ-040 Async reset mid-miss, plus stats under ICACHE_STATS_EN:
  - rst_in low between clock edges -> mem_req=0 immediately, and all lines miss afterward.
  - With ICACHE_STATS_EN after REQ-035..037: hit_cnt=1, miss_cnt=3.

Source files
------------

// File: rtl/icache_if.sv
// icache_if -- fetch-side and memory-side signals of the instruction cache.
// The cache takes the slave view and the fetcher/memory environment takes the master view.
// The hit_cnt/miss_cnt counters exist only when ICACHE_STATS_EN is defined.
interface icache_if;
   // fetcher side
   logic        fetch_able;
   logic [31:0] fetch_pc;
   logic        stall;
   logic        flush;
   logic        ins_ready;
   logic [31:0] ins;
   // memory-controller side
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   modport slave (
      input  fetch_able,
      input  fetch_pc,
      input  stall,
      input  flush,
      output ins_ready,
      output ins,
      output mem_req,
      output mem_addr,
      input  mem_resp_valid,
      input  mem_resp_data
`ifdef ICACHE_STATS_EN
      ,
      output hit_cnt,
      output miss_cnt
`endif
   );

   modport master (
      output fetch_able,
      output fetch_pc,
      output stall,
      output flush,
      input  ins_ready,
      input  ins,
      input  mem_req,
      input  mem_addr,
      output mem_resp_valid,
      output mem_resp_data
`ifdef ICACHE_STATS_EN
      ,
      input  hit_cnt,
      input  miss_cnt
`endif
   );
endinterface

// File: rtl/icache.sv
// icache -- direct-mapped instruction cache, one 32-bit word per line.
// A hit answers one edge after sampling; a miss issues a single word read and
// delivers the returned word on the response edge. A flush during a miss lets
// the read drain (the line is still filled) but the word is not delivered.
// Optional feature: define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counters.
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   icache_if.slave  bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MISS  = 3'd1,
      S_RESP  = 3'd2,
      S_GAP   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t state_reg, state_next;

   // line storage: tags and data need no reset, only the valid bits do
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];
   logic [LINES-1:0]    valid_reg;

   // registered outputs and the latched request word address
   logic        ins_ready_reg, ins_ready_next;
   logic [31:0] ins_reg,       ins_next;
   logic        mem_req_reg,   mem_req_next;
   logic [31:0] mem_addr_reg,  mem_addr_next;
   logic [31:2] pc_reg,        pc_next;

   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  lookup_hit;
   logic                  fill_en;

   assign req_index  = bus.fetch_pc[INDEX_BITS+1:2];
   assign req_tag    = bus.fetch_pc[31:INDEX_BITS+2];
   assign fill_index = pc_reg[INDEX_BITS+1:2];
   assign fill_tag   = pc_reg[31:INDEX_BITS+2];

   // lookup is combinational so that a hit is registered on the sampling edge
   assign lookup_hit = valid_reg[req_index] && (tag_mem[req_index] == req_tag);

   // a response only counts while a request is outstanding
   assign fill_en = rdy_in && bus.mem_resp_valid &&
                    ((state_reg == S_MISS) || (state_reg == S_DRAIN));

   assign bus.ins_ready = ins_ready_reg;
   assign bus.ins       = ins_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_addr  = mem_addr_reg;

   // State and output registers; reset abandons any outstanding request
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg     <= S_IDLE;
         ins_ready_reg <= 1'b0;
         ins_reg       <= 32'd0;
         mem_req_reg   <= 1'b0;
         mem_addr_reg  <= 32'd0;
         pc_reg        <= '0;
      end else begin
         state_reg     <= state_next;
         ins_ready_reg <= ins_ready_next;
         ins_reg       <= ins_next;
         mem_req_reg   <= mem_req_next;
         mem_addr_reg  <= mem_addr_next;
         pc_reg        <= pc_next;
      end
   end

   // Next-state logic; everything holds while rdy_in is low
   always_comb begin
      state_next = state_reg;
      if (rdy_in) begin
         case (state_reg)
            S_IDLE: begin
               if (!bus.flush && bus.fetch_able)
                  state_next = lookup_hit ? S_RESP : S_MISS;
            end
            S_MISS: begin
               // a flush coinciding with the response drops the word
               if (bus.mem_resp_valid)
                  state_next = bus.flush ? S_IDLE : S_RESP;
               else if (bus.flush)
                  state_next = S_DRAIN;
            end
            S_RESP: begin
               if (bus.flush)
                  state_next = S_IDLE;
               else if (!bus.stall)
                  state_next = S_GAP;
            end
            S_GAP:   state_next = S_IDLE;
            S_DRAIN: begin
               if (bus.mem_resp_valid)
                  state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Output logic: next values of the registered outputs and latched pc
   always_comb begin
      ins_ready_next = ins_ready_reg;
      ins_next       = ins_reg;
      mem_req_next   = mem_req_reg;
      mem_addr_next  = mem_addr_reg;
      pc_next        = pc_reg;
      if (rdy_in) begin
         case (state_reg)
            S_IDLE: begin
               if (bus.flush) begin
                  ins_ready_next = 1'b0;
               end else if (bus.fetch_able) begin
                  pc_next = bus.fetch_pc[31:2];
                  if (lookup_hit) begin
                     ins_next       = data_mem[req_index];
                     ins_ready_next = 1'b1;
                  end else begin
                     mem_req_next  = 1'b1;
                     mem_addr_next = {bus.fetch_pc[31:2], 2'b00};
                  end
               end
            end
            S_MISS: begin
               if (bus.mem_resp_valid) begin
                  mem_req_next = 1'b0;
                  if (!bus.flush) begin
                     ins_next       = bus.mem_resp_data;
                     ins_ready_next = 1'b1;
                  end
               end
            end
            S_RESP: begin
               if (bus.flush || !bus.stall)
                  ins_ready_next = 1'b0;
            end
            S_GAP: begin
               ins_ready_next = 1'b0;
            end
            S_DRAIN: begin
               if (bus.mem_resp_valid)
                  mem_req_next = 1'b0;
            end
            default: begin
               ins_ready_next = 1'b0;
               mem_req_next   = 1'b0;
            end
         endcase
      end
   end

   // Valid bits: cleared by reset, set when a fill lands
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         valid_reg <= '0;
      else if (fill_en)
         valid_reg[fill_index] <= 1'b1;
   end

   // Tag and data arrays written by the fill
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_mem[fill_index]  <= fill_tag;
         data_mem[fill_index] <= bus.mem_resp_data;
      end
   end

`ifdef ICACHE_STATS_EN
   logic        sample_hit;
   logic        sample_miss;
   logic [31:0] hit_cnt_reg;
   logic [31:0] miss_cnt_reg;

   assign sample_hit  = rdy_in && (state_reg == S_IDLE) && bus.fetch_able &&
                        !bus.flush && lookup_hit;
   assign sample_miss = rdy_in && (state_reg == S_IDLE) && bus.fetch_able &&
                        !bus.flush && !lookup_hit;

   // Hit/miss counters, free-running with natural wrap
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         hit_cnt_reg  <= 32'd0;
         miss_cnt_reg <= 32'd0;
      end else begin
         if (sample_hit)
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         if (sample_miss)
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
   end

   assign bus.hit_cnt  = hit_cnt_reg;
   assign bus.miss_cnt = miss_cnt_reg;
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache -- scoreboard bench for icache: expected words are queued when a
// fetch is driven and popped when ins_ready rises. Build with ICACHE_STATS_EN
// defined to also check the hit/miss counters.
module tb_icache;
   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   icache_if bus ();

   icache #(.INDEX_BITS(6)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   logic        rdy_seen = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Delivery monitor: each rising ins_ready consumes one scoreboard entry
   always @(posedge clk_in) begin
      #1;
      if (bus.ins_ready && !rdy_seen) begin
         if (exp_q.size() > 0)
            check_eq("sb_ins", bus.ins, exp_q.pop_front());
         else
            check_eq("spurious_rdy", {31'd0, bus.ins_ready}, 32'd0);
      end
      rdy_seen = bus.ins_ready;
   end

   // One fetch: hit or miss with a response 'delay' cycles after the request
   task automatic do_fetch(input logic [31:0] pc, input bit miss, input logic [31:0] word,
                           input int delay, input string tag);
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = pc;
      exp_q.push_back(word);
      tick();
      bus.fetch_able = 1'b0;
      check_eq({tag, "_memreq"}, {31'd0, bus.mem_req}, {31'd0, miss});
      if (miss) begin
         check_eq({tag, "_addr"}, bus.mem_addr, {pc[31:2], 2'b00});
         repeat (delay - 1) tick();
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = word;
         tick();
         bus.mem_resp_valid = 1'b0;
      end
      check_eq({tag, "_rdy"}, {31'd0, bus.ins_ready}, 32'd1);
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_in             = 1'b0;
      rdy_in             = 1'b1;
      bus.fetch_able     = 1'b0;
      bus.fetch_pc       = 32'd0;
      bus.stall          = 1'b0;
      bus.flush          = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 32'd0;

      // reset state
      tick();
      tick();
      check_eq("rst_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
      check_eq("rst_ins", bus.ins, 32'd0);
      check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
      #2 rst_in = 1'b1;
      tick();

      // cold miss on 0x100, response three cycles after the request
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = 32'h0000_0100;
      exp_q.push_back(32'h0050_0093);
      tick();
      bus.fetch_able = 1'b0;
      check_eq("cold_memreq", {31'd0, bus.mem_req}, 32'd1);
      check_eq("cold_addr", bus.mem_addr, 32'h0000_0100);
      tick();
      tick();
      check_eq("cold_memreq_hold", {31'd0, bus.mem_req}, 32'd1);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h0050_0093;
      tick();
      bus.mem_resp_valid = 1'b0;
      check_eq("cold_rdy", {31'd0, bus.ins_ready}, 32'd1);
      check_eq("cold_ins", bus.ins, 32'h0050_0093);
      check_eq("cold_memreq_drop", {31'd0, bus.mem_req}, 32'd0);

      // GAP ignores a waiting request; the IDLE edge after it samples a hit
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = 32'h0000_0100;
      exp_q.push_back(32'h0050_0093);
      tick();
      check_eq("gap_rdy", {31'd0, bus.ins_ready}, 32'd0);
      tick();
      check_eq("gap_ignore", {31'd0, bus.ins_ready}, 32'd0);
      tick();
      bus.fetch_able = 1'b0;
      check_eq("hit_rdy", {31'd0, bus.ins_ready}, 32'd1);
      check_eq("hit_ins", bus.ins, 32'h0050_0093);
      check_eq("hit_memreq", {31'd0, bus.mem_req}, 32'd0);
      tick();
      tick();

      // conflict: 0x200 evicts 0x100, which then misses again
      do_fetch(32'h0000_0200, 1'b1, 32'h1111_2222, 2, "conf200");
      do_fetch(32'h0000_0100, 1'b1, 32'h0050_0093, 1, "conf100");
`ifdef ICACHE_STATS_EN
      check_eq("stat_hit", bus.hit_cnt, 32'd1);
      check_eq("stat_miss", bus.miss_cnt, 32'd3);
`endif

      // stall hold for four cycles on a hit
      bus.stall      = 1'b1;
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = 32'h0000_0100;
      exp_q.push_back(32'h0050_0093);
      tick();
      bus.fetch_able = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq($sformatf("stall_rdy%0d", i), {31'd0, bus.ins_ready}, 32'd1);
         check_eq($sformatf("stall_ins%0d", i), bus.ins, 32'h0050_0093);
      end
      bus.stall = 1'b0;
      tick();
      check_eq("stall_consumed", {31'd0, bus.ins_ready}, 32'd0);
      tick();

      // flush mid-miss: the word is filled but never delivered
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = 32'h0000_0300;
      tick();
      bus.fetch_able = 1'b0;
      check_eq("flush_memreq", {31'd0, bus.mem_req}, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("drain_memreq", {31'd0, bus.mem_req}, 32'd1);
      check_eq("drain_rdy", {31'd0, bus.ins_ready}, 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hDEAD_BEEF;
      tick();
      bus.mem_resp_valid = 1'b0;
      check_eq("drain_done_rdy", {31'd0, bus.ins_ready}, 32'd0);
      check_eq("drain_done_memreq", {31'd0, bus.mem_req}, 32'd0);
      tick();

      // a stray response in IDLE must not touch the array
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h1234_5678;
      tick();
      bus.mem_resp_valid = 1'b0;
      do_fetch(32'h0000_0300, 1'b0, 32'hDEAD_BEEF, 0, "after_flush");

      // rdy_in low: request not sampled until it returns high
      rdy_in         = 1'b0;
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = 32'h0000_0300;
      exp_q.push_back(32'hDEAD_BEEF);
      tick();
      tick();
      check_eq("rdylow_rdy", {31'd0, bus.ins_ready}, 32'd0);
      check_eq("rdylow_memreq", {31'd0, bus.mem_req}, 32'd0);
      rdy_in = 1'b1;
      tick();
      bus.fetch_able = 1'b0;
      check_eq("rdyhigh_rdy", {31'd0, bus.ins_ready}, 32'd1);
      tick();
      tick();

      // asynchronous reset in the middle of a miss
      bus.fetch_able = 1'b1;
      bus.fetch_pc   = 32'h0000_0100;
      tick();
      bus.fetch_able = 1'b0;
      check_eq("arst_pre_memreq", {31'd0, bus.mem_req}, 32'd1);
      #3 rst_in = 1'b0;
      #1;
      check_eq("arst_memreq", {31'd0, bus.mem_req}, 32'd0);
      check_eq("arst_rdy", {31'd0, bus.ins_ready}, 32'd0);
      #1 rst_in = 1'b1;
      tick();
      do_fetch(32'h0000_0300, 1'b1, 32'hCAFE_F00D, 2, "post_rst");
`ifdef ICACHE_STATS_EN
      check_eq("post_rst_hit", bus.hit_cnt, 32'd0);
      check_eq("post_rst_miss", bus.miss_cnt, 32'd1);
`endif

      tick();
      check_eq("sb_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
